y_sobel_edge: RTL and testbench

//  Stage downstream of RGB2YCbCr: consumes the Y (luma) stream plus vsync/href and

---
 rtl/ycbcr_pkg.sv | 20 ++
 rtl/y_sobel_edge_if.sv | 23 ++
 rtl/y_line_buffer.sv | 35 +++
 rtl/y_sobel_edge.sv | 147 ++++++++++++++
 tb/tb_y_sobel_edge.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ycbcr_pkg.sv
// Shared types and defaults for the YCbCr processing chain (RGB2YCbCr, Sobel stages, benches).
package ycbcr_pkg;

  typedef logic [7:0]  pixel_t;
  typedef logic [10:0] mag_t;

  localparam int   LAT            = 4;
  localparam int   IMG_WIDTH_DEF  = 640;
  localparam int   IMG_HEIGHT_DEF = 480;
  localparam mag_t THRESHOLD_DEF  = 11'd128;

  function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic pixel_t sat8(input mag_t v);
    return (v > 11'd255) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/y_sobel_edge_if.sv
// Luma-in / edge-out video stream bundle between the Sobel stage and its neighbours.
interface y_sobel_edge_if;
  import ycbcr_pkg::*;

  logic   per_img_vsync;
  logic   per_img_href;
  pixel_t per_img_Y;
  logic   post_img_vsync;
  logic   post_img_href;
  pixel_t post_img_mag;
  logic   post_img_bit;

  modport master (
    output per_img_vsync, per_img_href, per_img_Y,
    input  post_img_vsync, post_img_href, post_img_mag, post_img_bit
  );

  modport slave (
    input  per_img_vsync, per_img_href, per_img_Y,
    output post_img_vsync, post_img_href, post_img_mag, post_img_bit
  );

endinterface

// File: rtl/y_line_buffer.sv
// Enabled delay line: dout is the din written DEPTH enabled cycles earlier (circular RAM).
module y_line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      ptr <= '0;
    else if (en)
      ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  end

  // NOTE: the RAM has no reset branch on purpose; a reset loop over every word would
  // forbid block-RAM mapping, and stale contents are masked by the border gate anyway.
  always_ff @(posedge sys_clk) begin
    if (en)
      mem[ptr] <= din;
  end

  // Read-before-write at the same slot yields the word from one full line ago.
  assign dout = mem[ptr];

endmodule

// File: rtl/y_sobel_edge.sv
// 3x3 Sobel gradient magnitude and thresholded edge bit on the Y stream, fixed 4-cycle latency.
module y_sobel_edge
  import ycbcr_pkg::*;
#(
  parameter int   IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int   IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter mag_t THRESHOLD  = THRESHOLD_DEF
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  y_sobel_edge_if.slave  img
);

  localparam int CW = $clog2(IMG_WIDTH + 1);
  localparam int RW = $clog2(IMG_HEIGHT + 1);

  logic          vsync_d, href_d;
  logic          vsync_rise, href_fall;
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  pixel_t        lb1_q, lb2_q;
  pixel_t        win [3][3];
  logic          border_now, border_s1, border_s2, border_s3;
  logic [9:0]    gx_p, gx_n, gy_p, gy_n;
  logic [9:0]    abs_x, abs_y;
  mag_t          edge_sum;
  logic [LAT-1:0] vs_dl, hr_dl;
  pixel_t        mag_q;
  logic          bit_q;

  assign vsync_rise = img.per_img_vsync & ~vsync_d;
  assign href_fall  = href_d & ~img.per_img_href;

  // NOTE: every clocked block uses <= so all registers sample pre-edge values;
  // blocking = here would make the window shift order-dependent.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      vsync_d <= 1'b0;
      href_d  <= 1'b0;
      col_cnt <= '0;
      row_cnt <= '0;
    end else begin
      vsync_d <= img.per_img_vsync;
      href_d  <= img.per_img_href;
      if (!img.per_img_href)
        col_cnt <= '0;
      else if (col_cnt != '1)
        col_cnt <= col_cnt + 1'b1;
      if (vsync_rise)
        row_cnt <= '0;
      else if (href_fall && row_cnt != '1)
        row_cnt <= row_cnt + 1'b1;
    end
  end

  y_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(8)) u_lb1 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (img.per_img_href),
    .din     (img.per_img_Y),
    .dout    (lb1_q)
  );

  y_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(8)) u_lb2 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (img.per_img_href),
    .din     (lb1_q),
    .dout    (lb2_q)
  );

  always_comb begin
    // NOTE: defaults first so no path through this block can infer a latch.
    border_now = 1'b0;
    edge_sum   = '0;
    // A vsync rise clears row_cnt this edge, so treat the current pixel as row 0 already.
    if (vsync_rise || row_cnt < RW'(2) || col_cnt < CW'(2))
      border_now = 1'b1;
    edge_sum = {1'b0, abs_x} + {1'b0, abs_y};
  end

  // S1: window, row 0 = oldest line, col 2 = newest pixel; holds while href is low.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win[i][j] <= '0;
      border_s1 <= 1'b0;
    end else begin
      border_s1 <= border_now;
      if (img.per_img_href) begin
        for (int i = 0; i < 3; i++) begin
          win[i][0] <= win[i][1];
          win[i][1] <= win[i][2];
        end
        win[0][2] <= lb2_q;
        win[1][2] <= lb1_q;
        win[2][2] <= img.per_img_Y;
      end
    end
  end

  // S2..S4 arithmetic plus the vsync/href delay lines that frame it.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      gx_p      <= '0;
      gx_n      <= '0;
      gy_p      <= '0;
      gy_n      <= '0;
      abs_x     <= '0;
      abs_y     <= '0;
      border_s2 <= 1'b0;
      border_s3 <= 1'b0;
      vs_dl     <= '0;
      hr_dl     <= '0;
      mag_q     <= '0;
      bit_q     <= 1'b0;
    end else begin
      gx_p <= {2'b00, win[0][2]} + {1'b0, win[1][2], 1'b0} + {2'b00, win[2][2]};
      gx_n <= {2'b00, win[0][0]} + {1'b0, win[1][0], 1'b0} + {2'b00, win[2][0]};
      gy_p <= {2'b00, win[2][0]} + {1'b0, win[2][1], 1'b0} + {2'b00, win[2][2]};
      gy_n <= {2'b00, win[0][0]} + {1'b0, win[0][1], 1'b0} + {2'b00, win[0][2]};
      border_s2 <= border_s1;

      abs_x     <= abs_diff(gx_p, gx_n);
      abs_y     <= abs_diff(gy_p, gy_n);
      border_s3 <= border_s2;

      vs_dl <= {vs_dl[LAT-2:0], img.per_img_vsync};
      hr_dl <= {hr_dl[LAT-2:0], img.per_img_href};

      if (hr_dl[LAT-2] && !border_s3) begin
        mag_q <= sat8(edge_sum);
        bit_q <= (edge_sum > THRESHOLD);
      end else begin
        mag_q <= '0;
        bit_q <= 1'b0;
      end
    end
  end

  assign img.post_img_vsync = vs_dl[LAT-1];
  assign img.post_img_href  = hr_dl[LAT-1];
  assign img.post_img_mag   = mag_q;
  assign img.post_img_bit   = bit_q;

endmodule

// File: tb/tb_y_sobel_edge.sv
// Directed bench for y_sobel_edge on a reduced 16x8 image; one DUT at THRESHOLD 128, one at 40.
module tb_y_sobel_edge;
  import ycbcr_pkg::*;

  localparam int W     = 16;
  localparam int H     = 8;
  localparam int HBL   = 4;
  localparam int MID_C = W / 2;
  localparam int MID_R = H / 2;

  typedef enum int {PAT_FLAT, PAT_VSTEP, PAT_HSTEP, PAT_THR10, PAT_THR11, PAT_RAND, PAT_RST} pat_e;

  // exp words are {vsync, href, mag[7:0], bit}
  typedef struct {
    logic        rst;
    logic        vs;
    logic        hr;
    logic [7:0]  y;
    logic [10:0] exp;
    logic [10:0] exp40;
    logic        care;
  } stim_t;

  logic  sys_clk = 1'b0;
  logic  sys_rst = 1'b0;
  stim_t q [$];
  stim_t hist [4];
  int    n_cmp = 0;
  int    n_bad = 0;

  always #5 sys_clk = ~sys_clk;

  y_sobel_edge_if img0 ();
  y_sobel_edge_if img40 ();

  assign img40.per_img_vsync = img0.per_img_vsync;
  assign img40.per_img_href  = img0.per_img_href;
  assign img40.per_img_Y     = img0.per_img_Y;

  y_sobel_edge #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .img     (img0)
  );

  y_sobel_edge #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESHOLD(11'd40)) dut40 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .img     (img40)
  );

  function automatic logic [7:0] pix(pat_e p, int r, int c);
    case (p)
      PAT_VSTEP: return (c < MID_C) ? 8'h00 : 8'hFF;
      PAT_HSTEP: return (r < MID_R) ? 8'h00 : 8'hFF;
      PAT_THR10: return (c < MID_C) ? 8'h40 : 8'h4A;
      PAT_THR11: return (c < MID_C) ? 8'h40 : 8'h4B;
      PAT_RST:   return (r <= 3)    ? 8'h00 : 8'h30;
      default:   return 8'h80;
    endcase
  endfunction

  // Hand-derived |Gx|+|Gy| per pattern, border pixels already forced to 0.
  function automatic logic [10:0] raw_edge(pat_e p, int r, int c);
    if (r < 2 || c < 2) return 11'd0;
    case (p)
      PAT_VSTEP: return (c == MID_C || c == MID_C + 1) ? 11'd1020 : 11'd0;
      PAT_HSTEP: return (r == MID_R || r == MID_R + 1) ? 11'd1020 : 11'd0;
      PAT_THR10: return (c == MID_C || c == MID_C + 1) ? 11'd40   : 11'd0;
      PAT_THR11: return (c == MID_C || c == MID_C + 1) ? 11'd44   : 11'd0;
      // Reset mid row 3 restarts row numbering: row 4 is gated, row 5 sees rows 3,4,5 = 0,30,30.
      PAT_RST:   return (r == 5) ? 11'd192 : 11'd0;
      default:   return 11'd0;
    endcase
  endfunction

  function automatic logic [10:0] out_word(logic vs, logic hr, logic [10:0] raw, logic [10:0] thr);
    logic [7:0] m;
    logic       b;
    m = (raw > 11'd255) ? 8'hFF : raw[7:0];
    b = (raw > thr);
    if (!hr) begin
      m = 8'h00;
      b = 1'b0;
    end
    return {vs, hr, m, b};
  endfunction

  function automatic stim_t mk(logic rst, logic vs, logic hr, logic [7:0] y, logic [10:0] raw, logic care);
    stim_t s;
    s.rst   = rst;
    s.vs    = vs;
    s.hr    = hr;
    s.y     = y;
    s.exp   = out_word(vs, hr, raw, 11'd128);
    s.exp40 = out_word(vs, hr, raw, 11'd40);
    s.care  = care;
    return s;
  endfunction

  task automatic build_frame(input pat_e p, input int lead);
    for (int i = 0; i < lead; i++) q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 11'd0, 1'b1));
    for (int i = 0; i < 2; i++)    q.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 11'd0, 1'b1));
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        logic [7:0] y;
        y = (p == PAT_RAND) ? 8'($urandom_range(0, 255)) : pix(p, r, c);
        q.push_back(mk((p == PAT_RST) && r == 3 && c >= 5 && c < 8, 1'b1, 1'b1, y,
                       raw_edge(p, r, c), p != PAT_RAND));
      end
      for (int i = 0; i < HBL; i++) q.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 11'd0, 1'b1));
    end
    for (int i = 0; i < 4; i++) q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 11'd0, 1'b1));
  endtask

  // Samples outputs, returns the expectation pushed four ticks ago, then drives the next input.
  task automatic tick(input stim_t s, output logic [10:0] obs, output logic [10:0] obs40, output stim_t m);
    @(negedge sys_clk);
    obs   = {img0.post_img_vsync, img0.post_img_href, img0.post_img_mag, img0.post_img_bit};
    obs40 = {img40.post_img_vsync, img40.post_img_href, img40.post_img_mag, img40.post_img_bit};
    m     = hist[3];
    hist[3] = hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = s;
    if (s.rst)
      for (int i = 0; i < 4; i++) hist[i] = mk(1'b0, 1'b0, 1'b0, 8'h00, 11'd0, 1'b1);
    sys_rst            = s.rst;
    img0.per_img_vsync = s.vs;
    img0.per_img_href  = s.hr;
    img0.per_img_Y     = s.y;
  endtask

  task automatic test_reset();
    logic [10:0] o, o40;
    stim_t       m;
    sys_rst = 1'b1;
    #1;
    n_cmp++;
    if ({img0.post_img_vsync, img0.post_img_href, img0.post_img_mag, img0.post_img_bit} !== 11'h000) begin
      n_bad++;
      $display("FAIL reset_async: got %h want 000",
               {img0.post_img_vsync, img0.post_img_href, img0.post_img_mag, img0.post_img_bit});
    end
    for (int i = 0; i < 3; i++) begin
      tick(mk(1'b1, 1'b1, 1'b1, 8'hFF, 11'd0, 1'b1), o, o40, m);
      n_cmp++;
      if (o !== m.exp) begin n_bad++; $display("FAIL reset_hold[%0d]: got %h want %h", i, o, m.exp); end
    end
    for (int i = 0; i < 6; i++) begin
      tick(mk(1'b0, 1'b0, 1'b0, 8'h00, 11'd0, 1'b1), o, o40, m);
      n_cmp++;
      if (o !== m.exp) begin n_bad++; $display("FAIL reset_idle[%0d]: got %h want %h", i, o, m.exp); end
    end
  endtask

  task automatic test_flat();
    logic [10:0] o, o40;
    stim_t       m;
    q.delete();
    build_frame(PAT_FLAT, 2);
    foreach (q[i]) begin
      tick(q[i], o, o40, m);
      n_cmp++;
      if (o !== m.exp) begin n_bad++; $display("FAIL flat[%0d]: got %h want %h", i, o, m.exp); end
    end
  endtask

  task automatic test_vstep();
    logic [10:0] o, o40;
    stim_t       m;
    q.delete();
    build_frame(PAT_VSTEP, 2);
    foreach (q[i]) begin
      tick(q[i], o, o40, m);
      n_cmp++;
      if (o !== m.exp) begin n_bad++; $display("FAIL vstep[%0d]: got %h want %h", i, o, m.exp); end
    end
  endtask

  task automatic test_hstep();
    logic [10:0] o, o40;
    stim_t       m;
    q.delete();
    build_frame(PAT_HSTEP, 2);
    foreach (q[i]) begin
      tick(q[i], o, o40, m);
      n_cmp++;
      if (o !== m.exp) begin n_bad++; $display("FAIL hstep[%0d]: got %h want %h", i, o, m.exp); end
    end
  endtask

  task automatic test_threshold();
    logic [10:0] o, o40;
    stim_t       m;
    q.delete();
    build_frame(PAT_THR10, 2);
    build_frame(PAT_THR11, 1);
    foreach (q[i]) begin
      tick(q[i], o, o40, m);
      n_cmp++;
      if (o !== m.exp) begin n_bad++; $display("FAIL thr_128[%0d]: got %h want %h", i, o, m.exp); end
      n_cmp++;
      if (o40 !== m.exp40) begin n_bad++; $display("FAIL thr_40[%0d]: got %h want %h", i, o40, m.exp40); end
    end
  endtask

  task automatic test_mid_reset();
    logic [10:0] o, o40, live;
    stim_t       m;
    logic        was_rst;
    was_rst = 1'b0;
    q.delete();
    build_frame(PAT_RST, 2);
    foreach (q[i]) begin
      tick(q[i], o, o40, m);
      n_cmp++;
      if (o !== m.exp) begin n_bad++; $display("FAIL mid_reset[%0d]: got %h want %h", i, o, m.exp); end
      if (q[i].rst && !was_rst) begin
        #1;
        live = {img0.post_img_vsync, img0.post_img_href, img0.post_img_mag, img0.post_img_bit};
        n_cmp++;
        if (live !== 11'h000) begin n_bad++; $display("FAIL mid_reset_async: got %h want 000", live); end
      end
      was_rst = q[i].rst;
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] o, o40, mask;
    stim_t       m;
    q.delete();
    build_frame(PAT_RAND, 2);
    build_frame(PAT_FLAT, 0);
    foreach (q[i]) begin
      tick(q[i], o, o40, m);
      mask = m.care ? 11'h7FF : 11'h600;
      n_cmp++;
      if ((o & mask) !== (m.exp & mask)) begin
        n_bad++;
        $display("FAIL back_to_back[%0d]: got %h want %h (mask %h)", i, o, m.exp, mask);
      end
    end
  endtask

  initial begin
    img0.per_img_vsync = 1'b0;
    img0.per_img_href  = 1'b0;
    img0.per_img_Y     = 8'h00;
    for (int i = 0; i < 4; i++) hist[i] = mk(1'b0, 1'b0, 1'b0, 8'h00, 11'd0, 1'b1);
    test_reset();
    test_flat();
    test_vstep();
    test_hstep();
    test_threshold();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
